demux_1to16_deser: RTL and testbench

- Registered 1-to-16 demultiplexer/deserializer: the receive-side counterpart of the 16:1 mux tree.
- Steers a stream of single-bit beats into 16 lane positions, either at an explicit lane address or at an auto-incrementing lane counter.
- Presents each completed 16-bit frame on a double-buffered valid/ready output.
- Sits downstream of any serializing 16:1 mux path and rebuilds the parallel word.

---
 rtl/demux_1to16_deser_pkg.sv | 13 +
 rtl/demux_1to16_deser_if.sv | 26 ++
 rtl/demux_1to16_deser_decoder.sv | 14 +
 rtl/demux_1to16_deser.sv | 114 +++++++++++
 tb/tb_demux_1to16_deser.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/demux_1to16_deser_pkg.sv
// Shared constants and state encoding for the 1-to-16 deserializer slice.
package demux_pkg;

    localparam int LANES = 16;
    localparam int SEL_W = 4;
    localparam logic [LANES-1:0] FULL_MASK = 16'hFFFF;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/demux_1to16_deser_if.sv
// Beat input and frame output bundle; the producer/consumer side uses master, the deserializer uses slave.
interface demux_1to16_deser_if;
    import demux_pkg::*;

    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [LANES-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] lane_strobe;
    logic             dup_err;

    modport master (
        output in_bit, in_valid, mode, sel, out_ready,
        input  in_ready, out, out_valid, lane_strobe, dup_err
    );

    modport slave (
        input  in_bit, in_valid, mode, sel, out_ready,
        output in_ready, out, out_valid, lane_strobe, dup_err
    );

endinterface

// File: rtl/demux_1to16_deser_decoder.sv
// Combinational 4-to-16 one-hot lane decoder.
module decoder_4to16
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] addr_i,
    output logic [LANES-1:0] onehot_o
);

    always_comb begin
        onehot_o         = '0;
        onehot_o[addr_i] = 1'b1;
    end

endmodule

// File: rtl/demux_1to16_deser.sv
// Registered 1-to-16 deserializer: steers single-bit beats into lanes and
// hands each completed 16-bit frame to a double-buffered valid/ready output.
module demux_1to16_deser
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    demux_1to16_deser_if.slave bus
);

    state_e           state_q, state_d;
    logic [LANES-1:0] shadow_q, shadow_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [LANES-1:0] out_q, out_d;
    logic             outValid_q, outValid_d;
    logic [LANES-1:0] strobe_q, strobe_d;
    logic             dupErr_q, dupErr_d;

    logic [SEL_W-1:0] laneAddr;
    logic [LANES-1:0] laneOnehot;
    logic [LANES-1:0] shadowWr;
    logic             accept;
    logic             consume;
    logic             complete;

    assign laneAddr = bus.mode ? cnt_q : bus.sel;

    decoder_4to16 u_decoder (
        .addr_i   (laneAddr),
        .onehot_o (laneOnehot)
    );

    assign bus.in_ready    = !rst && (state_q == S_FILL);
    assign accept          = bus.in_valid && bus.in_ready;
    assign consume         = outValid_q && bus.out_ready;
    assign complete        = accept && ((mask_q | laneOnehot) == FULL_MASK);
    assign shadowWr        = bus.in_bit ? (shadow_q | laneOnehot) : (shadow_q & ~laneOnehot);

    assign bus.out         = out_q;
    assign bus.out_valid   = outValid_q;
    assign bus.lane_strobe = strobe_q;
    assign bus.dup_err     = dupErr_q;

    // A completed frame loads straight into the output slot when it is free or
    // being consumed this cycle; otherwise it parks in the shadow (S_HOLD).
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        outValid_d = consume ? 1'b0 : outValid_q;
        strobe_d   = '0;
        dupErr_d   = 1'b0;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    shadow_d = shadowWr;
                    mask_d   = mask_q | laneOnehot;
                    strobe_d = laneOnehot;
                    dupErr_d = !bus.mode && ((mask_q & laneOnehot) != '0);
                    if (bus.mode) begin
                        cnt_d = cnt_q + SEL_W'(1);
                    end
                    if (complete) begin
                        if (!outValid_q || consume) begin
                            out_d      = shadowWr;
                            outValid_d = 1'b1;
                            mask_d     = '0;
                            cnt_d      = '0;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (consume) begin
                    out_d      = shadow_q;
                    outValid_d = 1'b1;
                    mask_d     = '0;
                    cnt_d      = '0;
                    state_d    = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            shadow_q   <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            outValid_q <= 1'b0;
            strobe_q   <= '0;
            dupErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
            strobe_q   <= strobe_d;
            dupErr_q   <= dupErr_d;
        end
    end

endmodule

// File: tb/tb_demux_1to16_deser.sv
// Scoreboard bench for demux_1to16_deser: stimulus pushes expected frames,
// a negedge monitor pops and compares on every output handshake.
module tb_demux_1to16_deser;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int checkCount = 0;
    int passCount  = 0;

    logic [LANES-1:0] expQ[$];
    logic [LANES-1:0] word;
    logic             dupSeen;
    logic             dropped;

    demux_1to16_deser_if ifc();

    demux_1to16_deser dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic b, input logic m,
                                 input logic [SEL_W-1:0] s);
        ifc.in_valid = valid;
        ifc.in_bit   = b;
        ifc.mode     = m;
        ifc.sel      = s;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [LANES-1:0] actual,
                               input logic [LANES-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic sendSeqFrame(input logic [LANES-1:0] w);
        for (int i = 0; i < LANES; i++) begin
            if (i == LANES - 1) expQ.push_back(w);
            applyStimulus(1'b1, w[i], 1'b1, '0);
        end
        ifc.in_valid = 1'b0;
    endtask

    // Every output handshake consumes the oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ifc.out_valid && ifc.out_ready) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected frame: got %h, expected no frame", ifc.out);
                end else begin
                    checkOutput("scoreboard frame", ifc.out, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_bit    = 1'b0;
        ifc.mode      = 1'b0;
        ifc.sel       = '0;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset in_ready", {15'b0, ifc.in_ready}, 16'h0);
        checkOutput("reset out", ifc.out, 16'h0);
        checkOutput("reset out_valid", {15'b0, ifc.out_valid}, 16'h0);
        checkOutput("reset lane_strobe", ifc.lane_strobe, 16'h0);
        checkOutput("reset dup_err", {15'b0, ifc.dup_err}, 16'h0);
        rst = 1'b0;
        #1;
        checkOutput("post-reset in_ready", {15'b0, ifc.in_ready}, 16'h1);

        $display("[TB] sequential fill");
        ifc.out_ready = 1'b1;
        word = 16'hA5C3;
        for (int i = 0; i < LANES; i++) begin
            if (i == LANES - 1) expQ.push_back(word);
            applyStimulus(1'b1, word[i], 1'b1, '0);
            checkOutput("seq lane_strobe", ifc.lane_strobe, 16'(1) << i);
            checkOutput("seq out_valid", {15'b0, ifc.out_valid}, (i == LANES - 1) ? 16'h1 : 16'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("seq consumed", {15'b0, ifc.out_valid}, 16'h0);

        $display("[TB] addressed fill");
        word    = 16'h1234;
        dupSeen = 1'b0;
        for (int j = LANES - 1; j >= 0; j--) begin
            if (j == 0) expQ.push_back(word);
            applyStimulus(1'b1, word[j], 1'b0, 4'(j));
            dupSeen = dupSeen | ifc.dup_err;
        end
        checkOutput("addr out_valid", {15'b0, ifc.out_valid}, 16'h1);
        checkOutput("addr dup_err", {15'b0, dupSeen}, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        $display("[TB] duplicate write");
        word = 16'h5A5A;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3);
        checkOutput("first write dup_err", {15'b0, ifc.dup_err}, 16'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3);
        checkOutput("dup pulse", {15'b0, ifc.dup_err}, 16'h1);
        for (int j = 0; j < LANES; j++) begin
            if (j != 3) begin
                if (j == LANES - 1) expQ.push_back(word);
                applyStimulus(1'b1, word[j], 1'b0, 4'(j));
                if (j == 0) checkOutput("dup single pulse", {15'b0, ifc.dup_err}, 16'h0);
                if (j == 14) checkOutput("dup early complete", {15'b0, ifc.out_valid}, 16'h0);
            end
        end
        checkOutput("dup frame valid", {15'b0, ifc.out_valid}, 16'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        $display("[TB] backpressure");
        ifc.out_ready = 1'b0;
        sendSeqFrame(16'h00FF);
        sendSeqFrame(16'hFF00);
        checkOutput("hold in_ready", {15'b0, ifc.in_ready}, 16'h0);
        checkOutput("hold out", ifc.out, 16'h00FF);
        checkOutput("hold out_valid", {15'b0, ifc.out_valid}, 16'h1);
        tick();
        checkOutput("hold stays", {15'b0, ifc.in_ready}, 16'h0);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        checkOutput("release out", ifc.out, 16'hFF00);
        checkOutput("release out_valid", {15'b0, ifc.out_valid}, 16'h1);
        checkOutput("release in_ready", {15'b0, ifc.in_ready}, 16'h1);

        $display("[TB] simultaneous consume/complete");
        word    = 16'h3C96;
        dropped = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i == LANES - 1) begin
                ifc.out_ready = 1'b1;
                expQ.push_back(word);
            end
            applyStimulus(1'b1, word[i], 1'b1, '0);
            if (!ifc.out_valid) dropped = 1'b1;
        end
        ifc.in_valid = 1'b0;
        checkOutput("simul no gap", {15'b0, dropped}, 16'h0);
        checkOutput("simul out", ifc.out, 16'h3C96);
        tick();
        checkOutput("simul consumed", {15'b0, ifc.out_valid}, 16'h0);
        ifc.out_ready = 1'b0;

        $display("[TB] reset mid-operation");
        sendSeqFrame(16'h7E81);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, i[0], 1'b1, '0);
        end
        ifc.in_valid = 1'b0;
        checkOutput("pre-reset out_valid", {15'b0, ifc.out_valid}, 16'h1);
        void'(expQ.pop_back());
        rst = 1'b1;
        tick();
        checkOutput("mid reset out", ifc.out, 16'h0);
        checkOutput("mid reset out_valid", {15'b0, ifc.out_valid}, 16'h0);
        checkOutput("mid reset lane_strobe", ifc.lane_strobe, 16'h0);
        checkOutput("mid reset in_ready", {15'b0, ifc.in_ready}, 16'h0);
        rst           = 1'b0;
        ifc.out_ready = 1'b1;
        word          = 16'hBEEF;
        for (int i = 0; i < LANES; i++) begin
            if (i == LANES - 1) expQ.push_back(word);
            applyStimulus(1'b1, word[i], 1'b1, '0);
            if (i == 0) checkOutput("post-reset lane 0", ifc.lane_strobe, 16'h0001);
        end
        ifc.in_valid = 1'b0;
        checkOutput("post-reset frame", ifc.out, 16'hBEEF);
        tick();
        checkOutput("post-reset consumed", {15'b0, ifc.out_valid}, 16'h0);
        checkOutput("scoreboard drained", 16'(expQ.size()), 16'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
